// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 640x480@60 raster constants, derived totals,
// FSM state type and an integer window helper shared by the scan-out logic.
package video_timing_pkg;

    localparam int VT_CLK_DIV  = 5;
    localparam int VT_H_SYNC   = 96;
    localparam int VT_H_BP     = 48;
    localparam int VT_H_ACTIVE = 640;
    localparam int VT_H_FP     = 16;
    localparam int VT_V_SYNC   = 2;
    localparam int VT_V_BP     = 33;
    localparam int VT_V_ACTIVE = 480;
    localparam int VT_V_FP     = 10;

    localparam int VT_H_TOTAL =
        VT_H_SYNC + VT_H_BP + VT_H_ACTIVE + VT_H_FP;
    localparam int VT_V_TOTAL =
        VT_V_SYNC + VT_V_BP + VT_V_ACTIVE + VT_V_FP;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vt_state_e;

    // 11-bit so an upper bound of exactly 1024 still compares correctly.
    function automatic logic in_win(
        input logic [10:0] v,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pix_prefetch.sv
// pix_prefetch: one-deep pixel holding register with valid/ready intake.
// Ports: clk_i/rst_i; fetch_i (window where a pixel may be taken),
// slot_end_i (slot boundary), enter_act_i (boundary into an active slot),
// pix_valid_i/pix_rgb_i/pix_ready_o (upstream handshake),
// rgb_o (pixel shown for the current slot), uf_evt_o (underflow strobe).
module pix_prefetch
    import video_timing_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_i,
    input  logic        slot_end_i,
    input  logic        enter_act_i,
    input  logic        pix_valid_i,
    input  logic [23:0] pix_rgb_i,
    output logic        pix_ready_o,
    output logic [23:0] rgb_o,
    output logic        uf_evt_o
);

    logic        got_q;
    logic        got_d;
    logic [23:0] hold_q;
    logic [23:0] hold_d;
    logic [23:0] rgb_q;
    logic [23:0] rgb_d;
    logic        xfer;

    // fetch_i is never high in the last phase of a slot, so a transfer
    // can not coincide with the boundary that consumes the pixel.
    assign pix_ready_o = fetch_i && !got_q;
    assign xfer        = pix_valid_i && pix_ready_o;
    assign uf_evt_o    = enter_act_i && !got_q;
    assign rgb_o       = rgb_q;

    always_comb begin
        got_d  = got_q;
        hold_d = hold_q;
        rgb_d  = rgb_q;
        if (xfer) begin
            got_d  = 1'b1;
            hold_d = pix_rgb_i;
        end
        if (slot_end_i) begin
            got_d = 1'b0;
            rgb_d = (enter_act_i && got_q) ? hold_q : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            got_q  <= 1'b0;
            hold_q <= '0;
            rgb_q  <= '0;
        end else begin
            got_q  <= got_d;
            hold_q <= hold_d;
            rgb_q  <= rgb_d;
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: slot phase / load strobe, raster counters, IDLE/RUN FSM.
// Ports: clk_x5/reset; enable; pix_valid/pix_rgb/pix_ready (source);
// load, de, hsync, vsync, rgb, x, y, line_start, frame_start (scan-out);
// underflow (sticky) with clr_underflow.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int CLK_DIV  = VT_CLK_DIV,
    parameter int H_SYNC   = VT_H_SYNC,
    parameter int H_BP     = VT_H_BP,
    parameter int H_ACTIVE = VT_H_ACTIVE,
    parameter int H_FP     = VT_H_FP,
    parameter int V_SYNC   = VT_V_SYNC,
    parameter int V_BP     = VT_V_BP,
    parameter int V_ACTIVE = VT_V_ACTIVE,
    parameter int V_FP     = VT_V_FP
) (
    input  logic        clk_x5,
    input  logic        reset,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_ready,
    output logic        load,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic        underflow,
    input  logic        clr_underflow
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int PW      = $clog2(CLK_DIV);

    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SY   = 10'(H_SYNC);
    localparam logic [9:0]  V_SY   = 10'(V_SYNC);
    localparam logic [9:0]  H_A0   = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  V_A0   = 10'(V_SYNC + V_BP);
    localparam logic [10:0] H_A1   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_A1   = 11'(V_SYNC + V_BP + V_ACTIVE);

    if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_cfg_err
        $error("video_timing_ctrl: timing parameters out of range");
    end

    logic [PW-1:0] p_q, p_d;
    logic          load_q;
    vt_state_e     state_q, state_d;
    logic [9:0]    hc_q, hc_d;
    logic [9:0]    vc_q, vc_d;
    logic          uf_q, uf_d;

    logic       slot_end;
    logic       run;
    logic       h_end;
    logic       frame_end;
    logic [9:0] hc_nx;
    logic [9:0] vc_nx;
    logic       cur_act;
    logic       next_act;
    logic       fetch;
    logic       enter_act;
    logic       uf_evt;

    assign slot_end  = (p_q == P_LAST);
    assign p_d       = slot_end ? '0 : p_q + PW'(1);
    assign run       = (state_q == RUN);
    assign h_end     = (hc_q == H_LAST);
    assign frame_end = h_end && (vc_q == V_LAST);

    // Position of the slot that follows the current one while running.
    assign hc_nx = h_end ? '0 : hc_q + 10'd1;
    assign vc_nx = !h_end ? vc_q :
                   (vc_q == V_LAST) ? '0 : vc_q + 10'd1;

    assign cur_act = run
        && in_win({1'b0, hc_q}, {1'b0, H_A0}, H_A1)
        && in_win({1'b0, vc_q}, {1'b0, V_A0}, V_A1);

    // Leaving RUN only happens at a frame end, whose successor
    // (hc=vc=0) is never active, so enable need not be consulted.
    assign next_act = run
        && in_win({1'b0, hc_nx}, {1'b0, H_A0}, H_A1)
        && in_win({1'b0, vc_nx}, {1'b0, V_A0}, V_A1);

    assign fetch     = next_act && !slot_end;
    assign enter_act = slot_end && next_act;

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        if (slot_end) begin
            unique case (state_q)
                IDLE: begin
                    hc_d = '0;
                    vc_d = '0;
                    if (enable) state_d = RUN;
                end
                RUN: begin
                    hc_d = hc_nx;
                    vc_d = vc_nx;
                    if (frame_end && !enable) state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        uf_d = uf_q;
        if (uf_evt) begin
            uf_d = 1'b1;
        end else if (clr_underflow) begin
            uf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_x5 or posedge reset) begin
        if (reset) begin
            p_q     <= '0;
            load_q  <= 1'b0;
            state_q <= IDLE;
            hc_q    <= '0;
            vc_q    <= '0;
            uf_q    <= 1'b0;
        end else begin
            p_q     <= p_d;
            load_q  <= (p_d == P_LAST);
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            uf_q    <= uf_d;
        end
    end

    pix_prefetch u_prefetch (
        .clk_i       (clk_x5),
        .rst_i       (reset),
        .fetch_i     (fetch),
        .slot_end_i  (slot_end),
        .enter_act_i (enter_act),
        .pix_valid_i (pix_valid),
        .pix_rgb_i   (pix_rgb),
        .pix_ready_o (pix_ready),
        .rgb_o       (rgb),
        .uf_evt_o    (uf_evt)
    );

    assign load        = load_q;
    assign de          = cur_act;
    assign hsync       = run && (hc_q < H_SY);
    assign vsync       = run && (vc_q < V_SY);
    assign x           = cur_act ? hc_q - H_A0 : '0;
    assign y           = cur_act ? vc_q - V_A0 : '0;
    assign line_start  = run && (p_q == '0) && (hc_q == '0);
    assign frame_start = line_start && (vc_q == '0);
    assign underflow   = uf_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb_video_timing_ctrl: small-raster bench with a slot-count reference
// model, a raster checkpoint table and directed underflow/stop/reset cases.
module tb_video_timing_ctrl;

    localparam int D  = 5;
    localparam int HS = 3, HB = 2, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FR = HT * VT;

    logic        clk_x5 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic        clr_underflow = 1'b0;
    logic        pix_ready, load, de, hsync, vsync;
    logic [23:0] rgb;
    logic [9:0]  x, y;
    logic        line_start, frame_start, underflow;

    always #5 clk_x5 = ~clk_x5;

    video_timing_ctrl #(
        .CLK_DIV(D), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
    ) dut (
        .clk_x5(clk_x5), .reset(reset), .enable(enable),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_ready(pix_ready),
        .load(load), .de(de), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .underflow(underflow), .clr_underflow(clr_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since reset, running flag, slot count
    // since the run began, queue of accepted pixels.
    int          m_n = 0;
    bit          m_run = 0;
    int          m_s = 0;
    logic [23:0] m_q[$];
    logic [23:0] m_rgb = '0;
    bit          m_uf = 0;
    logic [23:0] src = 24'd1;

    function automatic bit act(int h, int v);
        return h >= HS + HB && h < HS + HB + HA &&
               v >= VS + VB && v < VS + VB + VA;
    endfunction
    function automatic int mp();
        return m_n % D;
    endfunction
    function automatic int m_hc();
        return m_run ? m_s % HT : 0;
    endfunction
    function automatic int m_vc();
        return m_run ? (m_s / HT) % VT : 0;
    endfunction
    function automatic bit m_ready();
        int s1 = m_s + 1;
        return m_run && act(s1 % HT, (s1 / HT) % VT) &&
               mp() <= D - 2 && m_q.size() == 0;
    endfunction

    task automatic expect_eq(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all();
        int h, v, p;
        bit de_e;
        logic [51:0] e, a;
        h = m_hc(); v = m_vc(); p = mp();
        de_e = m_run && act(h, v);
        e = {m_ready(), 1'(p == D - 1), de_e,
             1'(m_run && h < HS), 1'(m_run && v < VS), m_rgb,
             de_e ? 10'(h - HS - HB) : 10'd0,
             de_e ? 10'(v - VS - VB) : 10'd0,
             1'(m_run && p == 0 && h == 0),
             1'(m_run && p == 0 && h == 0 && v == 0), m_uf};
        a = {pix_ready, load, de, hsync, vsync, rgb, x, y,
             line_start, frame_start, underflow};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL model cyc=%0d slot=%0d: got %h expected %h",
                     m_n, m_s, a, e);
        end
    endtask

    task automatic model_step(input bit en, input bit clr, input bit xfer,
                              input logic [23:0] din);
        bit uf_evt = 0;
        if (xfer) m_q.push_back(din);
        if (mp() == D - 1) begin
            if (!m_run) begin
                if (en) begin m_run = 1; m_s = 0; end
            end else if (m_s % FR == FR - 1 && !en) begin
                m_run = 0; m_s = 0;
            end else begin
                m_s++;
            end
            if (m_run && act(m_hc(), m_vc())) begin
                if (m_q.size() > 0) m_rgb = m_q.pop_front();
                else begin m_rgb = '0; uf_evt = 1; end
            end else begin
                m_rgb = '0;
            end
            m_q.delete();
        end
        if (uf_evt) m_uf = 1;
        else if (clr) m_uf = 0;
        m_n++;
    endtask

    task automatic tick(input bit en, input bit vld, input logic [23:0] din,
                        input bit clr, output bit xfer);
        enable = en; pix_valid = vld; pix_rgb = din; clr_underflow = clr;
        xfer = vld && m_ready();
        model_step(en, clr, xfer, din);
        @(negedge clk_x5);
        check_all();
    endtask

    task automatic stick(input bit en, input bit vld, input bit clr);
        bit xf;
        tick(en, vld, src, clr, xf);
        if (xf) src++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_n = 0; m_run = 0; m_s = 0; m_q.delete(); m_rgb = '0; m_uf = 0;
        expect_eq("reset_outs",
                  {pix_ready, load, de, hsync, vsync, rgb, x, y,
                   line_start, frame_start, underflow}, 32'd0);
        check_all();
        @(negedge clk_x5);
        reset = 1'b0;
    endtask

    task automatic timeout(input string name, input int guard,
                           input int lim);
        n_tests++;
        if (guard >= lim) begin
            n_fail++;
            $display("FAIL %s: got timeout after %0d cycles expected event",
                     name, guard);
        end
    endtask

    typedef struct {
        int s; bit hs; bit vs; bit de; int x; int y;
        bit ls; bit fs; logic [23:0] rgb;
    } rast_t;

    rast_t tbl[14];

    initial begin
        int guard;
        bit en_r;
        bit xf;
        logic [31:0] got_v, exp_v;

        tbl[0]  = '{0,   1, 1, 0, 0, 0, 1, 1, 24'd0};
        tbl[1]  = '{2,   1, 1, 0, 0, 0, 0, 0, 24'd0};
        tbl[2]  = '{3,   0, 1, 0, 0, 0, 0, 0, 24'd0};
        tbl[3]  = '{15,  1, 1, 0, 0, 0, 1, 0, 24'd0};
        tbl[4]  = '{30,  1, 0, 0, 0, 0, 1, 0, 24'd0};
        tbl[5]  = '{64,  0, 0, 0, 0, 0, 0, 0, 24'd0};
        tbl[6]  = '{65,  0, 0, 1, 0, 0, 0, 0, 24'd1};
        tbl[7]  = '{72,  0, 0, 1, 7, 0, 0, 0, 24'd8};
        tbl[8]  = '{73,  0, 0, 0, 0, 0, 0, 0, 24'd0};
        tbl[9]  = '{110, 0, 0, 1, 0, 3, 0, 0, 24'd25};
        tbl[10] = '{117, 0, 0, 1, 7, 3, 0, 0, 24'd32};
        tbl[11] = '{125, 0, 0, 0, 0, 0, 0, 0, 24'd0};
        tbl[12] = '{149, 0, 0, 0, 0, 0, 0, 0, 24'd0};
        tbl[13] = '{150, 1, 1, 0, 0, 0, 1, 1, 24'd0};

        // Reset state and idle: load every 5th cycle, first at cycle 4.
        repeat (2) @(negedge clk_x5);
        check_all();
        expect_eq("reset_state",
                  {pix_ready, load, de, hsync, vsync, rgb, x, y,
                   line_start, frame_start, underflow}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(0, 1'($urandom_range(0, 1)), 24'($urandom), 0, xf);
            expect_eq("idle_load", {31'd0, load}, {31'd0, 1'(i % D == 3)});
        end

        // Raster checkpoints, incrementing source always valid.
        foreach (tbl[k]) begin
            guard = 0;
            while (!(m_run && m_s == tbl[k].s && mp() == 0) && guard < 2000)
            begin
                stick(1, 1, 0);
                guard++;
            end
            timeout("raster_reach", guard, 2000);
            got_v = {hsync, vsync, de, x, y, line_start, frame_start};
            exp_v = {tbl[k].hs, tbl[k].vs, tbl[k].de, 10'(tbl[k].x),
                     10'(tbl[k].y), tbl[k].ls, tbl[k].fs};
            expect_eq($sformatf("raster_s%0d", tbl[k].s), got_v, exp_v);
            expect_eq($sformatf("rgb_s%0d", tbl[k].s),
                      {8'd0, rgb}, {8'd0, tbl[k].rgb});
        end

        // Underflow: no pixel offered in the slot before x=3, row 0.
        guard = 0;
        while (!(m_s == 218 && mp() == 0) && guard < 1000) begin
            stick(1, !(m_s == 217), 0);
            guard++;
        end
        timeout("uf_reach", guard, 1000);
        expect_eq("uf_rgb_zero", {8'd0, rgb}, 32'd0);
        expect_eq("uf_set", {31'd0, underflow}, 32'd1);
        repeat (3 * D) stick(1, 1, 0);
        expect_eq("uf_sticky", {31'd0, underflow}, 32'd1);

        // New underflow with clr on the same edge: flag stays set.
        guard = 0;
        while (!(m_s == 230 && mp() == 0) && guard < 1000) begin
            stick(1, !(m_s == 229), m_s == 229 && mp() == D - 1);
            guard++;
        end
        timeout("uf2_reach", guard, 1000);
        expect_eq("uf_vs_clr", {31'd0, underflow}, 32'd1);
        stick(1, 1, 1);
        expect_eq("uf_clr", {31'd0, underflow}, 32'd0);

        // Source only valid from p=3: still accepted in time.
        guard = 0;
        while (!(m_s == 256 && mp() == 0) && guard < 1000) begin
            stick(1, (m_s >= 240) ? (mp() >= 3) : 1'b1, 0);
            guard++;
        end
        timeout("late_reach", guard, 1000);
        expect_eq("late_no_uf", {31'd0, underflow}, 32'd0);

        // Stop mid-frame: the frame completes, then IDLE.
        guard = 0;
        while (!(m_s == 375) && guard < 1000) begin
            stick(1, 1, 0);
            guard++;
        end
        timeout("stop_reach", guard, 1000);
        guard = 0;
        while (m_run && guard < 1500) begin
            stick(0, 1, 0);
            guard++;
        end
        timeout("stop_idle", guard, 1500);
        expect_eq("idle_outs", {hsync, vsync, de, line_start, frame_start},
                  32'd0);
        repeat (30) stick(0, 1, 0);
        guard = 0;
        while (!(m_run && m_s == 0 && mp() == 0) && guard < 100) begin
            stick(1, 1, 0);
            guard++;
        end
        timeout("restart", guard, 100);
        expect_eq("restart_outs", {hsync, vsync, line_start, frame_start},
                  32'hF);

        // Reset in the middle of the frame, with a pixel held.
        guard = 0;
        while (!(m_s == 64 && mp() == 2) && guard < 1000) begin
            stick(1, 1, 0);
            guard++;
        end
        timeout("rst_reach", guard, 1000);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            stick(1, 1, 0);
            expect_eq("rst_load", {31'd0, load}, {31'd0, 1'(i == 3)});
        end

        // Randomized run with an occasional reset.
        en_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) en_r = !en_r;
            if (i == 2000) do_reset();
            tick(en_r, $urandom_range(0, 3) != 0, 24'($urandom),
                 $urandom_range(0, 15) == 0, xf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
